// File: rtl/tl_ul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_ul_pkg : shared TileLink-UL opcodes, default widths, arbiter state |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tl_ul_pkg;

    localparam int DEF_ADDR_WIDTH   = 64;
    localparam int DEF_DATA_WIDTH   = 64;
    localparam int DEF_STRB_WIDTH   = DEF_DATA_WIDTH / 8;
    localparam int DEF_SOURCE_WIDTH = 3;
    localparam int DEF_SINK_WIDTH   = 3;
    localparam int DEF_OPCODE_WIDTH = 3;
    localparam int DEF_PARAM_WIDTH  = 3;
    localparam int DEF_SIZE_WIDTH   = 8;

    localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
    localparam logic [2:0] GET_A              = 3'd4;
    localparam logic [2:0] ACCESS_ACK_D       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA_D  = 3'd1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/tl_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_rr_picker : rotate-priority picker, first req after ptr wins      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tl_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int w_j;

    // Scan farthest-first so the nearest candidate after ptr overwrites last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        w_j = 0;
        for (int k = N; k >= 1; k--) begin
            w_j = (int'(ptr) + k) % N;
            if (req[w_j]) begin
                idx = IDX_W'(w_j);
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tl_ul_a_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_ul_a_arbiter : N-master TL-UL A arbiter with tagged D return path  |
// | Optional perf counters with TL_ARB_PERF_EN.  Rev 1.0                  |
// +----------------------------------------------------------------------+
module tl_ul_a_arbiter
    import tl_ul_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TL_ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int TL_DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int TL_STRB_WIDTH   = DEF_STRB_WIDTH,
    parameter int TL_SOURCE_WIDTH = DEF_SOURCE_WIDTH,
    parameter int TL_SINK_WIDTH   = DEF_SINK_WIDTH,
    parameter int TL_OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int TL_PARAM_WIDTH  = DEF_PARAM_WIDTH,
    parameter int TL_SIZE_WIDTH   = DEF_SIZE_WIDTH,
    localparam int IDX_W          = $clog2(NUM_MASTERS),
    localparam int TAG_W          = TL_SOURCE_WIDTH + IDX_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MASTERS-1:0]                 m_a_valid,
    output logic [NUM_MASTERS-1:0]                 m_a_ready,
    input  logic [NUM_MASTERS*TL_OPCODE_WIDTH-1:0] m_a_opcode,
    input  logic [NUM_MASTERS*TL_PARAM_WIDTH-1:0]  m_a_param,
    input  logic [NUM_MASTERS*TL_SIZE_WIDTH-1:0]   m_a_size,
    input  logic [NUM_MASTERS*TL_SOURCE_WIDTH-1:0] m_a_source,
    input  logic [NUM_MASTERS*TL_ADDR_WIDTH-1:0]   m_a_address,
    input  logic [NUM_MASTERS*TL_STRB_WIDTH-1:0]   m_a_mask,
    input  logic [NUM_MASTERS*TL_DATA_WIDTH-1:0]   m_a_data,
    output logic [NUM_MASTERS-1:0]                 m_d_valid,
    input  logic [NUM_MASTERS-1:0]                 m_d_ready,
    output logic [TL_OPCODE_WIDTH-1:0]             m_d_opcode,
    output logic [TL_PARAM_WIDTH-1:0]              m_d_param,
    output logic [TL_SIZE_WIDTH-1:0]               m_d_size,
    output logic [TL_SOURCE_WIDTH-1:0]             m_d_source,
    output logic [TL_SINK_WIDTH-1:0]               m_d_sink,
    output logic [TL_DATA_WIDTH-1:0]               m_d_data,
    output logic                                   m_d_error,
    output logic                                   s_a_valid,
    input  logic                                   s_a_ready,
    output logic [TL_OPCODE_WIDTH-1:0]             s_a_opcode,
    output logic [TL_PARAM_WIDTH-1:0]              s_a_param,
    output logic [TL_SIZE_WIDTH-1:0]               s_a_size,
    output logic [TAG_W-1:0]                       s_a_source,
    output logic [TL_ADDR_WIDTH-1:0]               s_a_address,
    output logic [TL_STRB_WIDTH-1:0]               s_a_mask,
    output logic [TL_DATA_WIDTH-1:0]               s_a_data,
    input  logic                                   s_d_valid,
    output logic                                   s_d_ready,
    input  logic [TL_OPCODE_WIDTH-1:0]             s_d_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]              s_d_param,
    input  logic [TL_SIZE_WIDTH-1:0]               s_d_size,
    input  logic [TAG_W-1:0]                       s_d_source,
    input  logic [TL_SINK_WIDTH-1:0]               s_d_sink,
    input  logic [TL_DATA_WIDTH-1:0]               s_d_data,
    input  logic                                   s_d_error,
    output logic                                   d_route_err
`ifdef TL_ARB_PERF_EN
    ,
    output logic [NUM_MASTERS*32-1:0]              perf_grant_cnt,
    output logic [31:0]                            perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    arb_state_t                           r_state;
    logic [IDX_W-1:0]                     r_grant;
    logic [IDX_W-1:0]                     r_rr_ptr;
    logic [NUM_MASTERS-1:0][CNT_W-1:0]    r_out_cnt;
    logic                                 r_route_err;

    logic [NUM_MASTERS-1:0] w_eligible;
    logic [NUM_MASTERS-1:0] w_inc;
    logic [NUM_MASTERS-1:0] w_dec;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic                   w_busy;
    logic                   w_a_fire;
    logic [IDX_W-1:0]       w_d_idx;
    logic                   w_d_idx_ok;
    logic                   w_d_fire;
    int                     w_g;

    tl_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req (w_eligible),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_busy      = (r_state == BUSY);
    assign w_g         = int'(r_grant);
    assign s_a_valid   = w_busy && m_a_valid[r_grant];
    assign w_a_fire    = s_a_valid && s_a_ready;
    assign s_a_opcode  = m_a_opcode[w_g*TL_OPCODE_WIDTH +: TL_OPCODE_WIDTH];
    assign s_a_param   = m_a_param[w_g*TL_PARAM_WIDTH +: TL_PARAM_WIDTH];
    assign s_a_size    = m_a_size[w_g*TL_SIZE_WIDTH +: TL_SIZE_WIDTH];
    assign s_a_source  = {r_grant, m_a_source[w_g*TL_SOURCE_WIDTH +: TL_SOURCE_WIDTH]};
    assign s_a_address = m_a_address[w_g*TL_ADDR_WIDTH +: TL_ADDR_WIDTH];
    assign s_a_mask    = m_a_mask[w_g*TL_STRB_WIDTH +: TL_STRB_WIDTH];
    assign s_a_data    = m_a_data[w_g*TL_DATA_WIDTH +: TL_DATA_WIDTH];

    assign w_d_idx    = s_d_source[TAG_W-1 -: IDX_W];
    assign w_d_idx_ok = int'(w_d_idx) < NUM_MASTERS;
    assign w_d_fire   = s_d_valid && s_d_ready;
    assign m_d_opcode = s_d_opcode;
    assign m_d_param  = s_d_param;
    assign m_d_size   = s_d_size;
    assign m_d_source = s_d_source[TL_SOURCE_WIDTH-1:0];
    assign m_d_sink   = s_d_sink;
    assign m_d_data   = s_d_data;
    assign m_d_error  = s_d_error;
    assign d_route_err = r_route_err;

    // Beats tagged with a nonexistent master are accepted and discarded.
    always_comb begin
        m_d_valid = '0;
        s_d_ready = 1'b0;
        if (!rst) begin
            if (w_d_idx_ok) begin
                m_d_valid[w_d_idx] = s_d_valid;
                s_d_ready          = m_d_ready[w_d_idx];
            end else begin
                s_d_ready = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_eligible[i] = m_a_valid[i] && (r_out_cnt[i] < c_CNT_MAX);
            m_a_ready[i]  = w_busy && s_a_ready && (r_grant == IDX_W'(i));
            w_inc[i]      = w_a_fire && (r_grant == IDX_W'(i));
            w_dec[i]      = w_d_fire && w_d_idx_ok && (w_d_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= IDX_W'(NUM_MASTERS - 1);
            r_out_cnt   <= '0;
            r_route_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_idx;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_a_fire) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= r_grant;
                    end
                end
                default: r_state <= IDLE;
            endcase

            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_out_cnt[i] <= r_out_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i] && (r_out_cnt[i] != '0)) begin
                    r_out_cnt[i] <= r_out_cnt[i] - CNT_W'(1);
                end
                if (w_dec[i] && (r_out_cnt[i] == '0)) begin
                    r_route_err <= 1'b1;
                end
            end
            if (w_d_fire && !w_d_idx_ok) begin
                r_route_err <= 1'b1;
            end
        end
    end

`ifdef TL_ARB_PERF_EN
    logic [NUM_MASTERS-1:0][31:0] r_perf_grant;
    logic [31:0]                  r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_grant <= '0;
            r_perf_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_inc[i]) begin
                    r_perf_grant[i] <= r_perf_grant[i] + 32'd1;
                end
            end
            if (w_busy && s_a_valid && !s_a_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_grant_cnt = r_perf_grant;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_a_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tl_ul_a_arbiter : directed scoreboard bench, 3 masters, cap of 2  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tl_ul_a_arbiter;
    import tl_ul_pkg::*;

    localparam int N = 3;

    typedef struct packed {
        logic [4:0]  src;
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  op;
    } exp_t;

    logic         clk, rst;
    logic [N-1:0] m_a_valid, m_a_ready, m_d_valid, m_d_ready;
    logic [N*3-1:0]  m_a_opcode, m_a_param, m_a_source;
    logic [N*8-1:0]  m_a_size, m_a_mask;
    logic [N*64-1:0] m_a_address, m_a_data;
    logic [2:0]  m_d_opcode, m_d_param, m_d_source, m_d_sink;
    logic [7:0]  m_d_size;
    logic [63:0] m_d_data;
    logic        m_d_error;
    logic        s_a_valid, s_a_ready;
    logic [2:0]  s_a_opcode, s_a_param;
    logic [7:0]  s_a_size, s_a_mask;
    logic [4:0]  s_a_source;
    logic [63:0] s_a_address, s_a_data;
    logic        s_d_valid, s_d_ready;
    logic [2:0]  s_d_opcode, s_d_param, s_d_sink;
    logic [7:0]  s_d_size;
    logic [4:0]  s_d_source;
    logic [63:0] s_d_data;
    logic        s_d_error, d_route_err;

    tl_ul_a_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
        .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
        .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
        .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source),
        .m_d_sink(m_d_sink), .m_d_data(m_d_data), .m_d_error(m_d_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_sink(s_d_sink), .s_d_data(s_d_data), .s_d_error(s_d_error),
        .d_route_err(d_route_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int left[2];
    int nreq[2];
    logic [2:0] opc[2];
    exp_t q0[$], q1[$];
    int fire_tag[$], fire_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input int i);
        exp_t e;
        e.src  = {2'(i), 3'(nreq[i] + 1 + i)};
        e.addr = (i == 0) ? 64'h10 + 64'(nreq[i] * 16) : 64'h1000 + 64'(nreq[i] * 16);
        e.data = (i == 0) ? (64'hCAFEBABE_DEADBEEF ^ 64'(nreq[i]))
                          : (64'h1111_2222_0000_0000 + 64'(nreq[i]));
        e.op   = opc[i];
        m_a_source[i*3 +: 3]   = e.src[2:0];
        m_a_address[i*64 +: 64] = e.addr;
        m_a_data[i*64 +: 64]   = e.data;
        m_a_opcode[i*3 +: 3]   = e.op;
        m_a_valid[i]           = 1'b1;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic start(input int i, input int n, input logic [2:0] op);
        left[i] = n;
        opc[i]  = op;
        present(i);
    endtask

    // One clock: observe at negedge, update master drivers just after posedge.
    task automatic cycle();
        logic [N-1:0] fired;
        exp_t e;
        int tag, qs;
        @(negedge clk);
        fired = m_a_valid & m_a_ready;
        if (s_a_valid && s_a_ready) begin
            tag = int'(s_a_source[4:3]);
            qs  = (tag == 0) ? q0.size() : (tag == 1) ? q1.size() : 0;
            chk("a_expected_beat", 64'(qs != 0), 64'd1);
            if (qs != 0) begin
                e = (tag == 0) ? q0.pop_front() : q1.pop_front();
                chk("a_source", 64'(s_a_source), 64'(e.src));
                chk("a_address", s_a_address, e.addr);
                chk("a_data", s_a_data, e.data);
                chk("a_opcode", 64'(s_a_opcode), 64'(e.op));
            end
            fire_tag.push_back(tag);
            fire_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (fired[i]) begin
                nreq[i]++;
                left[i]--;
                if (left[i] > 0) present(i); else m_a_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic d_beat(input logic [4:0] src, input logic [N-1:0] rdy,
                          input logic [N-1:0] exp_mdv, input logic exp_rdy);
        logic [63:0] dat;
        dat        = 64'hD0D0_0000_0000_0000 | 64'(src);
        s_d_valid  = 1'b1;
        s_d_source = src;
        s_d_opcode = ACCESS_ACK_DATA_D;
        s_d_data   = dat;
        m_d_ready  = rdy;
        #1;
        chk("d_valid_route", 64'(m_d_valid), 64'(exp_mdv));
        chk("d_ready", 64'(s_d_ready), 64'(exp_rdy));
        chk("d_source", 64'(m_d_source), 64'(src[2:0]));
        chk("d_data", m_d_data, dat);
        cycle();
        s_d_valid = 1'b0;
    endtask

    task automatic wait_done(input int i, input string tag);
        for (int k = 0; k < 20 && left[i] > 0; k++) cycle();
        chk(tag, 64'(left[i]), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        m_a_valid = '0; m_a_opcode = '0; m_a_param = '0; m_a_source = '0;
        m_a_size = {N{8'd3}}; m_a_mask = {N{8'hFF}}; m_a_address = '0; m_a_data = '0;
        m_d_ready = '0; s_a_ready = 1'b0;
        s_d_valid = 1'b0; s_d_opcode = '0; s_d_param = '0; s_d_size = '0;
        s_d_source = '0; s_d_sink = '0; s_d_data = '0; s_d_error = 1'b0;
        left[0] = 0; left[1] = 0; nreq[0] = 0; nreq[1] = 0;
        opc[0] = GET_A; opc[1] = GET_A;

        // Reset state
        #1;
        chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
        chk("rst_m_a_ready", 64'(m_a_ready), 64'd0);
        chk("rst_route_err", 64'(d_route_err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        chk("post_rst_s_a_valid", 64'(s_a_valid), 64'd0);

        // Single Put: one cycle to s_a_valid, then AccessAck back to m0
        s_a_ready = 1'b1;
        start(0, 1, PUT_FULL_DATA_A);
        chk("put_lat_idle", 64'(s_a_valid), 64'd0);
        cycle();
        chk("put_lat_valid", 64'(s_a_valid), 64'd1);
        chk("put_tagged_src", 64'(s_a_source), 64'b00_001);
        cycle();
        chk("put_done", 64'(left[0]), 64'd0);
        d_beat(5'b00_001, 3'b001, 3'b001, 1'b1);
        chk("put_no_err", 64'(d_route_err), 64'd0);

        // Fairness: last grant was m0, so m1 goes first
        fire_tag.delete(); fire_cyc.delete();
        start(0, 2, GET_A);
        start(1, 2, GET_A);
        for (int k = 0; k < 20 && (left[0] > 0 || left[1] > 0); k++) cycle();
        chk("fair_fires", 64'(fire_tag.size()), 64'd4);
        if (fire_tag.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("fair_order", 64'(fire_tag[k]), 64'((k % 2 == 0) ? 1 : 0));
                if (k > 0) chk("fair_gap", 64'(fire_cyc[k] - fire_cyc[k-1]), 64'd2);
            end
        end

        // Credit cap: both masters hold 2 outstanding
        start(0, 1, GET_A);
        repeat (4) cycle();
        chk("cap_m0_blocked", 64'(left[0]), 64'd1);
        chk("cap_no_valid", 64'(s_a_valid), 64'd0);
        d_beat(5'b01_010, 3'b111, 3'b010, 1'b1);
        start(1, 1, GET_A);
        wait_done(1, "cap_m1_granted");
        chk("cap_m0_still_blocked", 64'(left[0]), 64'd1);
        d_beat(5'b00_001, 3'b111, 3'b001, 1'b1);
        wait_done(0, "cap_m0_regranted");

        // Drain all credits
        for (int k = 0; k < 2; k++) begin
            d_beat(5'b00_001, 3'b111, 3'b001, 1'b1);
            d_beat(5'b01_010, 3'b111, 3'b010, 1'b1);
        end
        chk("drain_no_err", 64'(d_route_err), 64'd0);

        // Backpressure: m1 wins (last grant m0) and holds through 5 stalled cycles
        s_a_ready = 1'b0;
        start(0, 1, GET_A);
        start(1, 1, GET_A);
        cycle();
        chk("bp_valid", 64'(s_a_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_m1", 64'(s_a_source[4:3]), 64'd1);
            chk("bp_no_ready", 64'(m_a_ready), 64'd0);
        end
        s_a_ready = 1'b1;
        cycle();
        chk("bp_m1_fired", 64'(left[1]), 64'd0);
        chk("bp_m0_waiting", 64'(left[0]), 64'd1);
        wait_done(0, "bp_m0_after");

        // Routing error: index 3 does not exist
        d_beat(5'b11_000, 3'b000, 3'b000, 1'b1);
        chk("route_err_set", 64'(d_route_err), 64'd1);
        repeat (3) cycle();
        chk("route_err_sticky", 64'(d_route_err), 64'd1);

        // Reset while BUSY with m0 outstanding
        s_a_ready = 1'b0;
        start(0, 1, GET_A);
        cycle();
        chk("mid_busy", 64'(s_a_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_s_a_valid", 64'(s_a_valid), 64'd0);
        chk("mid_rst_m_a_ready", 64'(m_a_ready), 64'd0);
        chk("mid_rst_err_clear", 64'(d_route_err), 64'd0);
        m_a_valid = '0; left[0] = 0; q0.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        s_a_ready = 1'b1;
        start(0, 2, GET_A);
        wait_done(0, "post_rst_credits_full");

        // D to a master with no outstanding requests: delivered but flagged
        d_beat(5'b01_011, 3'b111, 3'b010, 1'b1);
        chk("zero_cnt_err", 64'(d_route_err), 64'd1);

        chk("sb_q0_empty", 64'(q0.size()), 64'd0);
        chk("sb_q1_empty", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
